// File: rtl/clkgen_pkg.sv
// clkgen_pkg: FSM state encoding and shared constants for the clock divider.
package clkgen_pkg;
    typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;
    localparam int MIN_DIV = 2;
endpackage

// File: rtl/clkgen_div_rst_sync.sv
// rst_sync: reset synchronizer, asynchronous assert and synchronous release after STAGES edges.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic RESETOUT
);
    logic [STAGES-1:0] q;
    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) q <= '0;
        else q <= {q[STAGES-2:0], 1'b1};
    assign RESETOUT = q[STAGES-1];
endmodule

// File: rtl/clkgen_div.sv
// clkgen_div: programmable clock divider with glitch-free ratio changes and a synchronized downstream reset.
module clkgen_div
    import clkgen_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             DIV_VALID,
    output logic             DIV_READY,
    output logic             CLKOUT,
    output logic             TICK,
    output logic             RESETOUT,
    output logic             RUNNING
);
    state_t state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx, r, r_nx, p, p_nx, div_san;
    logic pv, pv_nx, clkout_nx, tick_nx, acc, last;

    assign DIV_READY = !pv;
    assign RUNNING   = state != OFF;
    assign acc       = DIV_VALID && !pv;
    assign div_san   = DIV < WIDTH'(MIN_DIV) ? WIDTH'(MIN_DIV) : DIV;
    assign last      = cnt == r - WIDTH'(1);

    // Ratio changes are deferred to a period boundary so no short CLKOUT pulse can appear.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        r_nx      = r;
        p_nx      = p;
        pv_nx     = pv;
        clkout_nx = 1'b0;
        tick_nx   = 1'b0;
        if (state == OFF) begin
            cnt_nx = '0;
            if (pv) begin
                r_nx  = p;
                pv_nx = 1'b0;
            end
            if (acc) r_nx = div_san;
            if (EN) begin
                state_nx  = RUN;
                clkout_nx = 1'b1;
                tick_nx   = 1'b1;
            end
        end else begin
            if (last) begin
                cnt_nx = '0;
                if (pv) begin
                    r_nx  = p;
                    pv_nx = 1'b0;
                end
                state_nx  = EN ? RUN : OFF;
                clkout_nx = EN;
                tick_nx   = EN;
            end else begin
                cnt_nx    = cnt + WIDTH'(1);
                clkout_nx = cnt_nx < (r >> 1);
                state_nx  = EN ? RUN : DRAIN;
            end
            if (acc) begin
                p_nx  = div_san;
                pv_nx = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state  <= OFF;
            cnt    <= '0;
            r      <= WIDTH'(MIN_DIV);
            p      <= '0;
            pv     <= 1'b0;
            CLKOUT <= 1'b0;
            TICK   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            r      <= r_nx;
            p      <= p_nx;
            pv     <= pv_nx;
            CLKOUT <= clkout_nx;
            TICK   <= tick_nx;
        end

    rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
        .CLK      (CLK),
        .RESET    (RESET),
        .RESETOUT (RESETOUT)
    );
endmodule

// File: tb/tb_clkgen_div.sv
// tb_clkgen_div: directed and randomized checks of clkgen_div against a period/phase reference model.
module tb_clkgen_div;
    localparam int W = 8;
    logic CLK = 1'b0, RESET = 1'b0, EN = 1'b0, DIV_VALID = 1'b0;
    logic [W-1:0] DIV = '0;
    logic DIV_READY, CLKOUT, TICK, RESETOUT, RUNNING;
    int errors = 0, checks = 0;
    int m_r, m_p, m_phase, m_state, m_rst;
    bit m_pv;

    always #5 CLK = ~CLK;

    clkgen_div #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .EN        (EN),
        .DIV       (DIV),
        .DIV_VALID (DIV_VALID),
        .DIV_READY (DIV_READY),
        .CLKOUT    (CLKOUT),
        .TICK      (TICK),
        .RESETOUT  (RESETOUT),
        .RUNNING   (RUNNING)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int san(input int d);
        return d < 2 ? 2 : d;
    endfunction

    task automatic model_reset();
        m_r = 2; m_p = 0; m_pv = 0; m_phase = 0; m_state = 0; m_rst = 0;
    endtask

    // Model state: mode (0 off, 1 run, 2 drain), phase within the current period, ratios.
    task automatic model_step();
        bit acc;
        int d;
        acc = DIV_VALID && !m_pv;
        d = san(int'(DIV));
        if (m_rst < 2) m_rst++;
        if (m_state == 0) begin
            if (m_pv) begin m_r = m_p; m_pv = 0; end
            if (acc) m_r = d;
            m_phase = 0;
            m_state = EN ? 1 : 0;
        end else begin
            if (m_phase == m_r - 1) begin
                if (m_pv) begin m_r = m_p; m_pv = 0; end
                m_phase = 0;
                m_state = EN ? 1 : 0;
            end else begin
                m_phase++;
                m_state = EN ? 1 : 2;
            end
            if (acc) begin m_p = d; m_pv = 1; end
        end
    endtask

    task automatic check_all(input string tag);
        bit run;
        run = m_state != 0;
        check({tag, ".clkout"}, 32'(CLKOUT), 32'(run && m_phase < m_r / 2));
        check({tag, ".tick"}, 32'(TICK), 32'(run && m_phase == 0));
        check({tag, ".running"}, 32'(RUNNING), 32'(run));
        check({tag, ".ready"}, 32'(DIV_READY), 32'(!m_pv));
        check({tag, ".resetout"}, 32'(RESETOUT), 32'(m_rst >= 2));
    endtask

    task automatic cycle(input string tag);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all(tag);
    endtask

    task automatic load(input int d);
        DIV = W'(d);
        DIV_VALID = 1'b1;
        cycle("load");
        DIV_VALID = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while (m_phase != ph && n < 300) begin
            cycle("wait");
            n++;
        end
        if (m_phase != ph) check("wait_phase_timeout", 32'(m_phase), 32'(ph));
    endtask

    task automatic async_reset(input string tag);
        RESET = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 RESET = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 check_all("reset");
        @(negedge CLK);
        RESET = 1'b1;
        cycle("rel_e1");
        check("rel_e1_rstout", 32'(RESETOUT), 32'd0);
        cycle("rel_e2");
        check("rel_e2_rstout", 32'(RESETOUT), 32'd1);
        check("rel_clkout", 32'(CLKOUT), 32'd0);
        check("rel_ready", 32'(DIV_READY), 32'd1);

        load(5);
        EN = 1'b1;
        for (int k = 0; k < 11; k++) begin
            cycle("r5");
            check("r5_clk", 32'(CLKOUT), 32'((k % 5) < 2));
            check("r5_tick", 32'(TICK), 32'((k % 5) == 0));
        end

        load(4);
        for (int k = 0; k < 10; k++) cycle("to_r4");
        wait_phase(1);
        load(7);
        check("live_ready_low", 32'(DIV_READY), 32'd0);
        for (int k = 0; k < 16; k++) cycle("live");

        load(6);
        for (int k = 0; k < 8; k++) cycle("to_r6");
        wait_phase(1);
        EN = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle("drain");
            check("drain_running", 32'(RUNNING), 32'd1);
        end
        cycle("stop");
        check("stop_running", 32'(RUNNING), 32'd0);
        check("stop_clkout", 32'(CLKOUT), 32'd0);

        for (int s = 0; s < 2; s++) begin
            load(s);
            EN = 1'b1;
            for (int k = 0; k < 4; k++) begin
                cycle("san");
                check("san_clk", 32'(CLKOUT), 32'((k % 2) == 0));
            end
            EN = 1'b0;
            for (int k = 0; k < 3; k++) cycle("san_stop");
        end

        load(8);
        EN = 1'b1;
        cycle("r8");
        wait_phase(2);
        check("pre_rst_clkout", 32'(CLKOUT), 32'd1);
        async_reset("mid_rst");
        check("mid_rst_clkout", 32'(CLKOUT), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle("post_rst");
            check("post_rst_clk", 32'(CLKOUT), 32'((k % 2) == 0));
        end

        for (int k = 0; k < 600; k++) begin
            EN = $urandom_range(0, 7) != 0;
            DIV_VALID = $urandom_range(0, 3) == 0;
            DIV = W'($urandom_range(0, 12));
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clkgen_div.md
CLKGEN_DIV -- requirements
Module: clkgen_div

Interface
REQ-001 Parameters SHALL be: WIDTH, 8, divider/ratio bit width; SYNC_STAGES, 2, reset-release synchronizer depth (legal range 2..4).
REQ-002 CLK  input  1  master clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 EN  input  1  level; 1 = run divider, 0 = stop after the current period.
REQ-005 DIV  input  WIDTH  requested division ratio N.
REQ-006 DIV_VALID  input  1  DIV offered this cycle.
REQ-007 DIV_READY  output  1  ratio request can be accepted this cycle.
REQ-008 CLKOUT  output  1  registered divided clock for downstream flop cells.
REQ-009 TICK  output  1  one-CLK pulse, registered, high in the same cycle CLKOUT goes 0->1.
REQ-010 RESETOUT  output  1  active-low reset for the CLKOUT domain: asynchronous assert, synchronous release.
REQ-011 RUNNING  output  1  high while state is RUN or DRAIN.

Function
REQ-012 Internal state: counter cnt[WIDTH-1:0], active ratio R, pending ratio P with flag PV, FSM {OFF, RUN, DRAIN}.
REQ-013 Ratio sanitizing: any accepted DIV < 2 SHALL be stored as 2; all other values stored unchanged.
REQ-014 Handshake: transfer occurs on a cycle with DIV_VALID=1 and DIV_READY=1; DIV_READY = !PV; DIV SHALL be ignored when DIV_READY=0.
REQ-015 In OFF, an accepted ratio SHALL load R directly (PV stays 0); in RUN/DRAIN it SHALL load P and set PV.
REQ-016 Waveform: CLKOUT=1 for cnt in 0..floor(R/2)-1, else 0; period = R CLK cycles; high time floor(R/2), low time ceil(R/2).
REQ-017 RUN step: if cnt==R-1 then cnt<=0, CLKOUT<=1, TICK<=1, and if PV then R<=P, PV<=0; else cnt<=cnt+1, CLKOUT<=(cnt+1 < floor(R/2)), TICK<=0.
REQ-018 A new ratio SHALL take effect only at a period boundary; no CLKOUT pulse shorter than floor(min(old,new)/2) cycles SHALL occur.
REQ-019 OFF->RUN: when EN sampled 1, next edge cnt<=0, CLKOUT<=1, TICK<=1 (latency 1 CLK).
REQ-020 RUN->DRAIN: when EN sampled 0 and cnt!=R-1; RUN->OFF directly when EN=0 and cnt==R-1 (CLKOUT<=0, TICK<=0).
REQ-021 DRAIN: counting continues per REQ-017; at cnt==R-1 go OFF with CLKOUT<=0, TICK<=0; EN returning to 1 in DRAIN SHALL return to RUN without truncating the period.
REQ-022 OFF: CLKOUT=0, TICK=0, cnt held at 0; PV applied to R on entry into OFF.
REQ-023 Simultaneous boundary and handshake acceptance: the boundary applies the old P; the newly accepted value becomes the new P with PV=1.
REQ-024 Counter SHALL never exceed R-1; WIDTH-bit arithmetic, no wrap beyond R-1.

Reset
REQ-025 RESET=0 SHALL immediately force: state OFF, cnt=0, R=2, PV=0, P=0, CLKOUT=0, TICK=0, RESETOUT=0.
REQ-026 RESETOUT SHALL deassert on the SYNC_STAGES-th rising CLK edge after RESET rises.
REQ-027 RESET asserted mid-period SHALL truncate CLKOUT asynchronously; no recovery of prior state.

Structure
REQ-028 Package clkgen_pkg SHALL hold the FSM state enum and constant MIN_DIV=2.
REQ-029 Sub-module rst_sync (SYNC_STAGES-deep chain of async-reset flops, D tied to 1) SHALL generate RESETOUT.

Verification
REQ-030 Reset release: RESET 0->1, EN=0 -> RESETOUT rises on edge 2, CLKOUT stays 0, DIV_READY=1.
REQ-031 Ratio 5: load DIV=5 in OFF, EN=1 -> CLKOUT pattern 1,1,0,0,0 repeating, TICK every 5th cycle, first TICK 1 cycle after EN.
REQ-032 Live change: running R=4, offer DIV=7 mid-period -> DIV_READY low until boundary, then 3 high/4 low; no short pulse.
REQ-033 Sanitize: DIV=0 and DIV=1 -> period 2 (1 high, 1 low).
REQ-034 Stop: EN=0 at cnt=1 with R=6 -> period completes (4 more cycles), then OFF, RUNNING=0, CLKOUT=0.
REQ-035 Async reset mid-run at cnt=2, R=8 -> CLKOUT, RESETOUT, TICK drop without a clock edge; R reads back 2.
